// File: rtl/rs_mdu_scheduler_pkg.sv
// Shared definitions for the MDU reservation-station scheduler.
// State encodings and default line geometry.
package rs_mdu_scheduler_pkg;

  localparam int RS_LINE_NUM   = 4;
  localparam int RS_LINE_IDX_W = 2;

  typedef enum logic [1:0] {
    RSS_IDLE   = 2'd0,
    RSS_ISSUE  = 2'd1,
    RSS_BUSY   = 2'd2,
    RSS_COMMIT = 2'd3
  } rss_state_e;

endpackage

// File: rtl/rs_mdu_scheduler_rr_select.sv
// Rotating-priority picker: first set request at or after ptr.
// Shared by the reservation-station schedulers.
module rr_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);

  logic [W-1:0] j;

  // Walk offsets high to low so the smallest offset wins.
  always_comb begin
    idx   = ptr;
    valid = 1'b0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = ptr + W'(k);
      if (req[j]) begin
        idx   = j;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_mdu_scheduler.sv
// MDU reservation-station scheduler: line allocation,
// rotating issue to the single MDU, commit strobes, release/flush.
module rs_mdu_scheduler
  import rs_mdu_scheduler_pkg::*;
#(
  parameter int LINE_NUM   = RS_LINE_NUM,
  parameter int LINE_IDX_W = RS_LINE_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  dispatch_valid,
  output logic                  dispatch_ready,
  output logic [LINE_NUM-1:0]   line_write_en,
  input  logic [LINE_NUM-1:0]   line_ready,
  output logic [LINE_NUM-1:0]   line_issue_en,
  output logic [LINE_NUM-1:0]   line_commit_en,
  input  logic [LINE_NUM-1:0]   line_release,
  output logic                  mdu_start,
  output logic [LINE_IDX_W-1:0] mdu_line,
  input  logic                  mdu_accept,
  input  logic                  mdu_done,
  output logic                  mdu_cancel
);

  logic [LINE_NUM-1:0]   busy, busy_n;
  logic [LINE_NUM-1:0]   issued, issued_n;
  logic [LINE_NUM-1:0]   free, alloc, rel;
  logic [LINE_NUM-1:0]   cand, cur_oh;
  logic [LINE_IDX_W-1:0] rr_ptr, rr_ptr_n;
  logic [LINE_IDX_W-1:0] line_n, gnt_idx;
  logic                  gnt_valid;
  rss_state_e            state, state_n;

  assign free           = ~busy;
  assign dispatch_ready = |free;
  // Isolate the lowest set bit of the free mask.
  assign alloc          = free & (~free + LINE_NUM'(1));
  assign line_write_en  = alloc &
    {LINE_NUM{dispatch_valid & dispatch_ready & ~flush}};
  assign rel            = line_release & busy;
  assign cand           = busy & ~issued & line_ready;
  assign cur_oh         = LINE_NUM'(1) << mdu_line;

  rr_select #(
    .N (LINE_NUM),
    .W (LINE_IDX_W)
  ) u_rr_select (
    .req   (cand),
    .ptr   (rr_ptr),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  always_comb begin
    state_n        = state;
    line_n         = mdu_line;
    rr_ptr_n       = rr_ptr;
    issued_n       = issued;
    mdu_start      = 1'b0;
    mdu_cancel     = 1'b0;
    line_issue_en  = '0;
    line_commit_en = '0;
    unique case (state)
      RSS_IDLE: begin
        if (gnt_valid) begin
          state_n  = RSS_ISSUE;
          line_n   = gnt_idx;
          rr_ptr_n = gnt_idx + LINE_IDX_W'(1);
        end
      end
      RSS_ISSUE: begin
        mdu_start = 1'b1;
        if (mdu_accept) begin
          state_n       = RSS_BUSY;
          line_issue_en = cur_oh;
          issued_n      = issued | cur_oh;
        end
      end
      RSS_BUSY: begin
        if (mdu_done) state_n = RSS_COMMIT;
      end
      RSS_COMMIT: begin
        line_commit_en = cur_oh;
        state_n        = RSS_IDLE;
      end
      default: state_n = RSS_IDLE;
    endcase
    busy_n   = (busy & ~rel) | line_write_en;
    issued_n = issued_n & ~rel & ~line_write_en;
    // Flush overrides everything except the rotation pointer.
    if (flush) begin
      mdu_cancel = (state == RSS_BUSY) |
                   ((state == RSS_ISSUE) & mdu_accept);
      line_issue_en  = '0;
      line_commit_en = '0;
      state_n        = RSS_IDLE;
      line_n         = mdu_line;
      rr_ptr_n       = rr_ptr;
      busy_n         = '0;
      issued_n       = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RSS_IDLE;
      busy     <= '0;
      issued   <= '0;
      rr_ptr   <= '0;
      mdu_line <= '0;
    end else begin
      state    <= state_n;
      busy     <= busy_n;
      issued   <= issued_n;
      rr_ptr   <= rr_ptr_n;
      mdu_line <= line_n;
    end
  end

endmodule

// File: doc/rs_mdu_scheduler.md
Name: rs_mdu_scheduler

Overview:
Controller for the MDU reservation-station lines.
- Allocates a free line to each dispatched MDU instruction.
- Selects one ready line at a time to issue to the single multi-cycle MDU, handshaking start/accept/done.
- Pulses the owning line's commit strobe when the MDU result returns.
- Frees lines on ROB retire and clears everything on pipeline flush.

Parameters:
LINE_NUM, 4, number of RS lines; power of two, at least 2.
LINE_IDX_W, 2, log2(LINE_NUM).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  pipeline flush; all lines freed, in-flight MDU operation cancelled
dispatch_valid  in  1  decoder has an MDU instruction for the RS
dispatch_ready  out  1  at least one line is free
line_write_en  out  LINE_NUM  one-hot write strobe to the allocated line
line_ready  in  LINE_NUM  per-line operands resolved (no outstanding refs)
line_issue_en  out  LINE_NUM  one-hot; pulses in the cycle the MDU accepts that line
line_commit_en  out  LINE_NUM  one-hot; pulses one cycle when that line's result is valid
line_release  in  LINE_NUM  ROB retire; frees the flagged lines
mdu_start  out  1  request to the MDU; held high until accepted
mdu_line  out  LINE_IDX_W  index of the line whose operands feed the MDU mux
mdu_accept  in  1  MDU took the operands
mdu_done  in  1  MDU result valid, one-cycle pulse
mdu_cancel  out  1  one-cycle abort to the MDU on flush while the MDU is busy

Behaviour:
- Per-line state flops: busy[i], issued[i]. All registers reset to 0 asynchronously on rst.
- Reset values: dispatch_ready=1 (all lines free), all strobes=0, mdu_start=0, mdu_line=0, mdu_cancel=0, FSM=IDLE, rr_ptr=0.
- Allocation:
  - dispatch_ready = |~busy, computed from registered state only; no same-cycle bypass of release.
  - line_write_en = lowest-index free line, masked by dispatch_valid & dispatch_ready & ~flush (combinational).
  - busy is set at the next edge and issued is cleared at that edge.
- Candidates: cand = busy & ~issued & line_ready.
- Selection: rotating priority. Scan starts at rr_ptr. On selection, rr_ptr <= selected index + 1, wrapping modulo LINE_NUM.
- FSM:
  - IDLE: if cand≠0, register the selected index into mdu_line and go to ISSUE.
  - ISSUE: mdu_start=1.
    - If mdu_accept, pulse line_issue_en[mdu_line], set issued[mdu_line], and go to BUSY.
    - mdu_line is stable while in ISSUE.
  - BUSY: wait for mdu_done, then go to COMMIT. mdu_done is ignored in any other state.
  - COMMIT: line_commit_en[mdu_line]=1 for exactly one cycle, then IDLE. Issue latency from IDLE back to IDLE is at least 4 cycles.
- The line stays busy after commit until line_release. Release clears both busy and issued.
- Release of an unallocated line is ignored.
- Same-cycle events:
  - Release and allocation in the same cycle, line full: release takes effect next cycle, so dispatch_ready stays 0 this cycle.
  - Release of the line currently in ISSUE/BUSY/COMMIT is a protocol error. The bench asserts this never happens. RTL clears busy but still completes the FSM.
  - Allocation to line i and release of a different line in the same cycle are both applied.
- Flush has priority over every other event. At the next edge:
  - busy=0, issued=0, FSM=IDLE, rr_ptr unchanged.
  - mdu_cancel=1 combinationally in the flush cycle if FSM is BUSY or (ISSUE & mdu_accept).
  - All line strobes are suppressed in the flush cycle.
- rst mid-operation: immediate return to reset values. No cancel is issued; the MDU is reset by the same rst.

Decomposition:
- Shared package/header: FSM state encodings (RSS_IDLE, RSS_ISSUE, RSS_BUSY, RSS_COMMIT, 2-bit bus), RS line count and index width macros.
- One natural sub-module: rr_select, a parameterised rotating-priority picker.
  - Inputs: request vector, start pointer.
  - Outputs: grant index, grant valid.
  - Also reusable for the ALU/LSU stations.

Test Plan:
1. Reset, then dispatch 4 back-to-back with line_ready=0 -> line_write_en 0001, 0010, 0100, 1000; dispatch_ready=0 after the 4th edge. A 5th dispatch_valid produces no strobe.
2. Line 2 ready, mdu_accept on the 2nd ISSUE cycle, mdu_done 3 cycles later -> mdu_start for 2 cycles with mdu_line=2; line_issue_en=0100 one cycle; line_commit_en=0100 one cycle; FSM IDLE after.
3. Lines 0,1,3 ready, rr_ptr=1, zero-wait accept/done -> issue order 1, 3, 0.
4. Full, line_release=0010 with dispatch_valid=1 -> no write that cycle; next cycle line_write_en=0010.
5. Flush during BUSY -> mdu_cancel=1 for one cycle; next cycle dispatch_ready=1, busy=0; a late mdu_done produces no commit strobe.
6. rst asserted while in ISSUE -> mdu_start drops immediately (asynchronous); outputs hold reset values until rst is deasserted.
